// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - opcodes, state encodings and datapath select codes for the multicycle control unit
package cpu_defs;

    localparam int OPW    = 6;
    localparam int ALUOPW = 3;

    localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPW-1:0] OP_AND   = 6'b010000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPW-1:0] OP_XORI  = 6'b010011;
    localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT   = 6'b100111;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b100110;
    localparam logic [OPW-1:0] OP_SW    = 6'b110000;
    localparam logic [OPW-1:0] OP_LW    = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPW-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OPW-1:0] OP_J     = 6'b111000;
    localparam logic [OPW-1:0] OP_JR    = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_e;

    localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOPW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOPW-1:0] ALU_SLL = 3'b010;
    localparam logic [ALUOPW-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOPW-1:0] ALU_AND = 3'b100;
    localparam logic [ALUOPW-1:0] ALU_SLT = 3'b110;
    localparam logic [ALUOPW-1:0] ALU_XOR = 3'b111;

    localparam logic [1:0] EXT_SHAMT = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_SIGN  = 2'b10;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LS,
        CL_BR,
        CL_JMP,
        CL_HALT,
        CL_UNDEF
    } op_class_e;

    // Instruction family decides the path through the FSM after ID.
    function automatic op_class_e op_class(input logic [OPW-1:0] op);
        op_class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLL, OP_SLT, OP_SLTI: c = CL_ALU;
            OP_SW, OP_LW:                     c = CL_LS;
            OP_BEQ, OP_BNE, OP_BLTZ:          c = CL_BR;
            OP_J, OP_JR, OP_JAL:              c = CL_JMP;
            OP_HALT:                          c = CL_HALT;
            default:                          c = CL_UNDEF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control unit bundle between IR/ALU flags and the datapath selects
interface multicycle_ctrl_if;
    import cpu_defs::*;

    logic [OPW-1:0]    opcode;
    logic              zero;
    logic              sign;
    logic [2:0]        state;
    logic              PCWre;
    logic              IRWre;
    logic              InsMemRW;
    logic              mRD;
    logic              mWR;
    logic              RegWre;
    logic [1:0]        RegDst;
    logic              WrRegDSrc;
    logic              DBDataSrc;
    logic              ALUSrcA;
    logic              ALUSrcB;
    logic [1:0]        ExtSel;
    logic [1:0]        PCSrc;
    logic [ALUOPW-1:0] ALUOp;

    modport master (
        input  opcode, zero, sign,
        output state, PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, RegDst,
               WrRegDSrc, DBDataSrc, ALUSrcA, ALUSrcB, ExtSel, PCSrc, ALUOp
    );

    modport slave (
        output opcode, zero, sign,
        input  state, PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, RegDst,
               WrRegDSrc, DBDataSrc, ALUSrcA, ALUSrcB, ExtSel, PCSrc, ALUOp
    );

endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational decode of state, opcode and ALU flags into datapath controls
module ctrl_decode
    import cpu_defs::*;
(
    input  state_e            state_i,
    input  logic [OPW-1:0]    opcode_i,
    input  logic              zero_i,
    input  logic              sign_i,
    output logic              pc_wre_o,
    output logic              ir_wre_o,
    output logic              ins_mem_rw_o,
    output logic              m_rd_o,
    output logic              m_wr_o,
    output logic              reg_wre_o,
    output logic [1:0]        reg_dst_o,
    output logic              wr_reg_d_src_o,
    output logic              db_data_src_o,
    output logic              alu_src_a_o,
    output logic              alu_src_b_o,
    output logic [1:0]        ext_sel_o,
    output logic [1:0]        pc_src_o,
    output logic [ALUOPW-1:0] alu_op_o
);

    op_class_e cls;
    logic      taken;

    assign cls = op_class(opcode_i);

    always_comb begin
        taken = 1'b0;
        case (opcode_i)
            OP_BEQ:  taken = zero_i;
            OP_BNE:  taken = ~zero_i;
            OP_BLTZ: taken = sign_i;
            default: taken = 1'b0;
        endcase
    end

    // Strobes: PC advances only in each instruction's final state, so HALT and
    // undefined opcodes never move the PC.
    always_comb begin
        pc_wre_o      = 1'b0;
        m_rd_o        = 1'b0;
        m_wr_o        = 1'b0;
        reg_wre_o     = 1'b0;
        db_data_src_o = 1'b0;
        ir_wre_o      = (state_i == ST_IF);
        ins_mem_rw_o  = (state_i == ST_IF);
        case (state_i)
            ST_ID: begin
                pc_wre_o  = (cls == CL_JMP);
                reg_wre_o = (opcode_i == OP_JAL);
            end
            ST_EXE_BR: pc_wre_o = 1'b1;
            ST_MEM: begin
                pc_wre_o = (opcode_i == OP_SW);
                m_rd_o   = (opcode_i == OP_LW);
                m_wr_o   = (opcode_i == OP_SW);
            end
            ST_WB_AL: begin
                pc_wre_o  = 1'b1;
                reg_wre_o = 1'b1;
            end
            ST_WB_LD: begin
                pc_wre_o      = 1'b1;
                reg_wre_o     = 1'b1;
                db_data_src_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ext_sel_o      = EXT_SIGN;
        alu_op_o       = ALU_ADD;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = 1'b0;
        reg_dst_o      = RD_RT;
        wr_reg_d_src_o = 1'b1;
        pc_src_o       = PC_NEXT;
        case (opcode_i)
            OP_ADD:   reg_dst_o = RD_RD;
            OP_SUB: begin
                alu_op_o  = ALU_SUB;
                reg_dst_o = RD_RD;
            end
            OP_ADDIU: alu_src_b_o = 1'b1;
            OP_AND: begin
                alu_op_o  = ALU_AND;
                reg_dst_o = RD_RD;
            end
            OP_ANDI: begin
                alu_op_o    = ALU_AND;
                ext_sel_o   = EXT_ZERO;
                alu_src_b_o = 1'b1;
            end
            OP_ORI: begin
                alu_op_o    = ALU_OR;
                ext_sel_o   = EXT_ZERO;
                alu_src_b_o = 1'b1;
            end
            OP_XORI: begin
                alu_op_o    = ALU_XOR;
                ext_sel_o   = EXT_ZERO;
                alu_src_b_o = 1'b1;
            end
            OP_SLL: begin
                alu_op_o    = ALU_SLL;
                ext_sel_o   = EXT_SHAMT;
                alu_src_a_o = 1'b1;
                reg_dst_o   = RD_RD;
            end
            OP_SLT: begin
                alu_op_o  = ALU_SLT;
                reg_dst_o = RD_RD;
            end
            OP_SLTI: begin
                alu_op_o    = ALU_SLT;
                alu_src_b_o = 1'b1;
            end
            OP_SW, OP_LW: alu_src_b_o = 1'b1;
            OP_BEQ, OP_BNE, OP_BLTZ: begin
                alu_op_o = ALU_SUB;
                pc_src_o = (taken && state_i == ST_EXE_BR) ? PC_BRANCH : PC_NEXT;
            end
            OP_J:  pc_src_o = PC_JUMP;
            OP_JR: pc_src_o = PC_RS;
            OP_JAL: begin
                pc_src_o       = PC_JUMP;
                reg_dst_o      = RD_RA;
                wr_reg_d_src_o = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM: state register and instruction sequencing
module multicycle_ctrl
    import cpu_defs::*;
(
    input  logic              CLK,
    input  logic              Reset,
    multicycle_ctrl_if.master bus
);

    state_e    state_q;
    state_e    state_d;
    op_class_e op_cls;

    assign op_cls    = op_class(bus.opcode);
    assign bus.state = state_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // HALT parks in ID; undefined opcodes fall back to IF as a NOP.
    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: begin
                case (op_cls)
                    CL_HALT: state_d = ST_ID;
                    CL_BR:   state_d = ST_EXE_BR;
                    CL_LS:   state_d = ST_EXE_LS;
                    CL_ALU:  state_d = ST_EXE_AL;
                    default: state_d = ST_IF;
                endcase
            end
            ST_EXE_AL: state_d = ST_WB_AL;
            ST_EXE_LS: state_d = ST_MEM;
            ST_MEM:    state_d = (bus.opcode == OP_LW) ? ST_WB_LD : ST_IF;
            default:   state_d = ST_IF;
        endcase
    end

    ctrl_decode u_decode (
        .state_i        (state_q),
        .opcode_i       (bus.opcode),
        .zero_i         (bus.zero),
        .sign_i         (bus.sign),
        .pc_wre_o       (bus.PCWre),
        .ir_wre_o       (bus.IRWre),
        .ins_mem_rw_o   (bus.InsMemRW),
        .m_rd_o         (bus.mRD),
        .m_wr_o         (bus.mWR),
        .reg_wre_o      (bus.RegWre),
        .reg_dst_o      (bus.RegDst),
        .wr_reg_d_src_o (bus.WrRegDSrc),
        .db_data_src_o  (bus.DBDataSrc),
        .alu_src_a_o    (bus.ALUSrcA),
        .alu_src_b_o    (bus.ALUSrcB),
        .ext_sel_o      (bus.ExtSel),
        .pc_src_o       (bus.PCSrc),
        .alu_op_o       (bus.ALUOp)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
    localparam logic [5:0] AND = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010;
    localparam logic [5:0] XORI = 6'b010011, SLL = 6'b011000, SLT = 6'b100111;
    localparam logic [5:0] SLTI = 6'b100110, SW = 6'b110000, LW = 6'b110001;
    localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
    localparam logic [5:0] HALT = 6'b111111;

    localparam int K_ALU = 0, K_SW = 1, K_LW = 2, K_BR = 3, K_JMP = 4, K_HALT = 5, K_UNDEF = 6;

    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    logic [5:0] defs [19] = '{ADD, SUB, ADDIU, AND, ANDI, ORI, XORI, SLL, SLT, SLTI,
                              SW, LW, BEQ, BNE, BLTZ, J, JR, JAL, HALT};

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int kind(input logic [5:0] op);
        if (op inside {ADD, SUB, ADDIU, AND, ANDI, ORI, XORI, SLL, SLT, SLTI}) return K_ALU;
        if (op == SW) return K_SW;
        if (op == LW) return K_LW;
        if (op inside {BEQ, BNE, BLTZ}) return K_BR;
        if (op inside {J, JR, JAL}) return K_JMP;
        if (op == HALT) return K_HALT;
        return K_UNDEF;
    endfunction

    // Cycle count of each instruction; an undefined opcode costs IF + ID.
    function automatic int exp_len(input int kd);
        case (kd)
            K_ALU, K_SW: return 4;
            K_LW:        return 5;
            K_BR:        return 3;
            default:     return 2;
        endcase
    endfunction

    function automatic logic [2:0] exp_state(input int kd, input int k);
        logic [2:0] t [5];
        case (kd)
            K_ALU:   t = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd0};
            K_SW:    t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
            K_LW:    t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
            K_BR:    t = '{3'd0, 3'd1, 3'd5, 3'd0, 3'd0};
            default: t = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        endcase
        return t[k];
    endfunction

    function automatic logic [1:0] exp_ext(input logic [5:0] op);
        if (op == SLL) return 2'b00;
        if (op inside {ANDI, ORI, XORI}) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [2:0] exp_aluop(input logic [5:0] op);
        case (op)
            SUB, BEQ, BNE, BLTZ: return 3'b001;
            SLL:                 return 3'b010;
            ORI:                 return 3'b011;
            AND, ANDI:           return 3'b100;
            SLT, SLTI:           return 3'b110;
            XORI:                return 3'b111;
            default:             return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] exp_regdst(input logic [5:0] op);
        if (op == JAL) return 2'b00;
        if (op inside {ADD, SUB, AND, SLT, SLL}) return 2'b10;
        return 2'b01;
    endfunction

    function automatic logic [1:0] exp_pcsrc(input logic [5:0] op, input logic z, input logic s);
        if (op inside {J, JAL}) return 2'b11;
        if (op == JR) return 2'b10;
        if ((op == BEQ && z) || (op == BNE && !z) || (op == BLTZ && s)) return 2'b01;
        return 2'b00;
    endfunction

    // Runs one instruction from IF and checks every cycle; ends in the next IF.
    task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
        int kd;
        int n;
        logic last;
        logic [2:0] es;
        kd = kind(op);
        n  = exp_len(kd);
        bus.opcode = op;
        bus.zero   = z;
        bus.sign   = s;
        #1;
        for (int k = 0; k < n; k++) begin
            es   = exp_state(kd, k);
            last = (k == n - 1);
            chk("state", {5'd0, bus.state}, {5'd0, es});
            chk("IRWre", {7'd0, bus.IRWre}, {7'd0, k == 0});
            chk("InsMemRW", {7'd0, bus.InsMemRW}, {7'd0, k == 0});
            chk("PCWre", {7'd0, bus.PCWre}, {7'd0, last && kd != K_UNDEF});
            chk("RegWre", {7'd0, bus.RegWre},
                {7'd0, last && (kd == K_ALU || kd == K_LW || op == JAL)});
            chk("mRD", {7'd0, bus.mRD}, {7'd0, kd == K_LW && es == 3'd3});
            chk("mWR", {7'd0, bus.mWR}, {7'd0, kd == K_SW && es == 3'd3});
            chk("DBDataSrc", {7'd0, bus.DBDataSrc}, {7'd0, es == 3'd4});
            chk("mWR_and_RegWre", {7'd0, bus.mWR & bus.RegWre}, 8'd0);
            if (k >= 1 && kd != K_UNDEF) begin
                chk("ExtSel", {6'd0, bus.ExtSel}, {6'd0, exp_ext(op)});
                chk("ALUSrcA", {7'd0, bus.ALUSrcA}, {7'd0, op == SLL});
                chk("ALUSrcB", {7'd0, bus.ALUSrcB},
                    {7'd0, op inside {ADDIU, ANDI, ORI, XORI, SLTI, LW, SW}});
                chk("RegDst", {6'd0, bus.RegDst}, {6'd0, exp_regdst(op)});
                chk("WrRegDSrc", {7'd0, bus.WrRegDSrc}, {7'd0, op != JAL});
                if (kd <= K_BR) chk("ALUOp", {5'd0, bus.ALUOp}, {5'd0, exp_aluop(op)});
            end
            if (last && kd != K_UNDEF) chk("PCSrc", {6'd0, bus.PCSrc}, {6'd0, exp_pcsrc(op, z, s)});
            @(negedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [5:0] op;
        logic       isdef;
        Reset      = 1'b0;
        bus.opcode = 6'd0;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_state", {5'd0, bus.state}, 8'd0);
        chk("rst_IRWre", {7'd0, bus.IRWre}, 8'd1);
        chk("rst_InsMemRW", {7'd0, bus.InsMemRW}, 8'd1);
        chk("rst_PCWre", {7'd0, bus.PCWre}, 8'd0);
        chk("rst_RegWre", {7'd0, bus.RegWre}, 8'd0);
        chk("rst_mWR", {7'd0, bus.mWR}, 8'd0);
        Reset = 1'b1;

        // Reset asserted while ADD sits in EXE_AL.
        bus.opcode = ADD;
        #1;
        chk("mid_if", {5'd0, bus.state}, 8'd0);
        @(negedge CLK); #1;
        chk("mid_id", {5'd0, bus.state}, 8'd1);
        @(negedge CLK); #1;
        chk("mid_exe_al", {5'd0, bus.state}, 8'd6);
        Reset = 1'b0;
        #1;
        chk("midrst_state", {5'd0, bus.state}, 8'd0);
        chk("midrst_IRWre", {7'd0, bus.IRWre}, 8'd1);
        chk("midrst_PCWre", {7'd0, bus.PCWre}, 8'd0);
        chk("midrst_RegWre", {7'd0, bus.RegWre}, 8'd0);
        chk("midrst_mWR", {7'd0, bus.mWR}, 8'd0);
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        chk("midrst_held_if", {5'd0, bus.state}, 8'd0);
        @(negedge CLK); #1;
        chk("post_rst_id", {5'd0, bus.state}, 8'd1);
        @(negedge CLK); #1;
        chk("post_rst_exe_al", {5'd0, bus.state}, 8'd6);
        @(negedge CLK); #1;
        chk("post_rst_wb_al", {5'd0, bus.state}, 8'd7);
        @(negedge CLK); #1;

        run_instr(ADD, 1'b0, 1'b0);
        run_instr(LW, 1'b0, 1'b0);
        run_instr(SW, 1'b1, 1'b0);
        run_instr(BEQ, 1'b1, 1'b0);
        run_instr(BEQ, 1'b0, 1'b1);
        run_instr(BNE, 1'b0, 1'b0);
        run_instr(BLTZ, 1'b0, 1'b1);
        run_instr(BLTZ, 1'b1, 1'b0);
        run_instr(JAL, 1'b0, 1'b0);
        run_instr(J, 1'b1, 1'b1);
        run_instr(JR, 1'b0, 1'b0);
        run_instr(ORI, 1'b0, 1'b0);
        run_instr(SLL, 1'b0, 1'b0);
        run_instr(XORI, 1'b1, 1'b0);
        run_instr(SLTI, 1'b0, 1'b1);
        run_instr(6'b001111, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do begin
                    op    = 6'($urandom_range(0, 63));
                    isdef = 1'b0;
                    for (int d = 0; d < 19; d++) if (defs[d] == op) isdef = 1'b1;
                end while (isdef);
            end else begin
                op = defs[$urandom_range(0, 17)];
            end
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // HALT parks in ID with the PC frozen until reset.
        bus.opcode = HALT;
        #1;
        chk("halt_if", {5'd0, bus.state}, 8'd0);
        @(negedge CLK); #1;
        for (int c = 0; c < 20; c++) begin
            chk("halt_state", {5'd0, bus.state}, 8'd1);
            chk("halt_PCWre", {7'd0, bus.PCWre}, 8'd0);
            @(negedge CLK); #1;
        end
        Reset = 1'b0;
        #1;
        chk("halt_rst_state", {5'd0, bus.state}, 8'd0);
        chk("halt_rst_IRWre", {7'd0, bus.IRWre}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview: Moore/Mealy control FSM for the multicycle CPU. Sequences every instruction through IF/ID/EXE/MEM/WB and drives all datapath selects, including the extender mode ExtSel (00 shamt, 01 zero-extend, 10 sign-extend). Sits between the IR opcode field plus ALU flags and the datapath muxes, register file, memories and PC.

Parameters:
OPW, 6, opcode width
ALUOPW, 3, ALU operation code width

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from end of IF
zero  in  1  ALU result == 0
sign  in  1  ALU result[31]
state  out  3  current FSM state (debug)
PCWre  out  1  PC load enable
IRWre  out  1  IR load enable
InsMemRW  out  1  instruction memory read
mRD  out  1  data memory read
mWR  out  1  data memory write
RegWre  out  1  register file write
RegDst  out  2  00 $31, 01 rt, 10 rd
WrRegDSrc  out  1  0 = PC+4, 1 = DB
DBDataSrc  out  1  0 = ALU, 1 = memory
ALUSrcA  out  1  1 = shamt (extender) as A
ALUSrcB  out  1  1 = extended immediate as B
ExtSel  out  2  extender mode
PCSrc  out  2  00 PC+4, 01 branch target, 10 rs, 11 jump target
ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 sltu, 110 slt, 111 xor

Behaviour:
- Opcodes: ADD 000000, SUB 000001, ADDIU 000010, AND 010000, ANDI 010001, ORI 010010, XORI 010011, SLL 011000, SLT 100111, SLTI 100110, SW 110000, LW 110001, BEQ 110100, BNE 110101, BLTZ 110110, J 111000, JR 111001, JAL 111010, HALT 111111.
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111. Only `state` is registered; all other outputs are combinational from state and opcode/flags.
- Reset low: state = IF immediately. In IF all writes are 0 except IRWre = 1 and InsMemRW = 1.
- Transitions: IF -> ID.
- From ID: J/JR/JAL -> IF. HALT -> ID (held). BEQ/BNE/BLTZ -> EXE_BR. SW/LW -> EXE_LS. Any other defined opcode -> EXE_AL. An undefined opcode -> IF as a NOP.
- Later states: EXE_AL -> WB_AL -> IF. EXE_BR -> IF. EXE_LS -> MEM. MEM -> IF for SW, -> WB_LD for LW. WB_LD -> IF.
- Cycle counts: J/JR/JAL 2, branch 3, R/I ALU 4, SW 4, LW 5.
- PCWre = 1 only in the final state of each instruction: ID for jumps, EXE_BR, WB_AL, MEM for SW, WB_LD. PCWre = 0 while halted and for undefined opcodes (the PC does not advance for a NOP).
- PCSrc: 11 for J/JAL, 10 for JR, 01 when a branch is taken, 00 otherwise.
- Branch taken: BEQ when zero = 1, BNE when zero = 0, BLTZ when sign = 1. For branches ALUOp = 001.
- ExtSel: 00 for SLL; 01 for ANDI/ORI/XORI; 10 for ADDIU/SLTI/LW/SW/branches and the default. ExtSel is valid from ID onward.
- ALUSrcA = 1 only for SLL. ALUSrcB = 1 for ADDIU/ANDI/ORI/XORI/SLTI/LW/SW.
- ALUOp: ADD/ADDIU/LW/SW 000, SUB 001, SLL 010, ORI 011, AND/ANDI 100, SLT/SLTI 110, XORI 111.
- RegWre = 1 in WB_AL and WB_LD, and in ID for JAL only.
- RegDst: 00 for JAL, 10 for R-type (ADD/SUB/AND/SLT/SLL), 01 otherwise.
- WrRegDSrc = 0 only for JAL. DBDataSrc = 1 only in WB_LD.
- mRD = 1 only in MEM for LW; mWR = 1 only in MEM for SW. Memory write and register write are never asserted in the same cycle.
- Reset mid-instruction: state returns to IF asynchronously and all write strobes drop in the same cycle.

Decomposition:
- Package cpu_defs: opcode localparams, state encodings, and the ALUOp, ExtSel, PCSrc and RegDst codes.
- Optional sub-module ctrl_decode: purely combinational, (state, opcode, zero, sign) -> control outputs. multicycle_ctrl keeps only the state register and next-state logic.

Test Plan:
- Reset low mid-EXE_AL, then release -> state = 000, IRWre = 1, PCWre/RegWre/mWR = 0 in the same cycle; IF follows.
- ADD (000000) -> states 000, 001, 110, 111, 000. In WB_AL: RegWre = 1, RegDst = 10, ALUOp = 000, PCWre = 1, PCSrc = 00.
- LW (110001) -> 5 cycles. In MEM: mRD = 1. In WB_LD: DBDataSrc = 1, RegDst = 01, ExtSel = 10. SW (110000) -> mWR = 1 and PCWre = 1 in MEM, returns to IF after 4 cycles.
- BEQ with zero = 1 -> PCSrc = 01 in EXE_BR. BEQ with zero = 0 -> PCSrc = 00. BLTZ with sign = 1 -> PCSrc = 01. Every branch takes 3 cycles.
- JAL (111010) -> in ID: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 11, PCWre = 1; next state IF.
- ORI -> ExtSel = 01, ALUOp = 011. SLL -> ExtSel = 00, ALUSrcA = 1. HALT -> state holds at 001 with PCWre = 0 for 20 cycles until Reset.
